op_sequencer: RTL and testbench

- Program sequencer for the fixed-point operation datapath (Qm.Q format, N bits wide).
- Holds a small instruction memory and a register stack of constants and intermediates.
- Issues one operation at a time to the datapath over a valid/ready handshake, then writes each result back to the stack.
- Sits between the neuron-model config loader and the operation datapath, so that equation-generated programs (e.g. membrane updates) run without a host in the loop.

---
 rtl/op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_op_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// Program sequencer for the fixed-point operation datapath: fetches stored
// instructions, issues them over valid/ready and writes results to a register stack.
module op_sequencer #(
  parameter int N          = 32,
  parameter int Q          = 16,
  parameter int STACK      = 5,
  parameter int PROG_DEPTH = 16,
  localparam int IW        = $clog2(STACK),
  localparam int AW        = $clog2(PROG_DEPTH),
  localparam int INSTR_W   = 2 + 3 * IW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW:0]        prog_len,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               const_we,
  input  logic [IW-1:0]      const_idx,
  input  logic [N-1:0]       const_value,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [1:0]         op_code,
  output logic [N-1:0]       op_a,
  output logic [N-1:0]       op_b,
  input  logic               op_result_valid,
  input  logic [N-1:0]       op_result,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [N-1:0]       result
);

  // Q only describes the number format seen by the datapath.
  if (Q >= N) begin : g_bad_q
    $error("op_sequencer: Q must be smaller than N");
  end

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_NEG = 2'b11} opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_FINISH} state_e;

  localparam logic [AW:0] MAX_LEN = PROG_DEPTH[AW:0];

  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW:0]        len_q, len_d;
  logic               err_q, err_d;
  logic [N-1:0]       res_q, res_d;
  logic [N-1:0]       hold_q, hold_d;
  logic [1:0]         opc_q, opc_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [IW-1:0]      dst_q, dst_d;
  logic [N-1:0]       stack_q [STACK];
  logic [N-1:0]       stack_d [STACK];
  logic [INSTR_W-1:0] imem_q  [PROG_DEPTH];

  logic [INSTR_W-1:0] instr;
  logic [1:0]         f_op;
  logic [IW-1:0]      f_s1, f_s2, f_dst;
  logic               fetch_ok;
  logic               last_instr;
  logic [AW:0]        len_clamped;
  logic [N-1:0]       rd_a, rd_b;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return int'(idx) < STACK;
  endfunction

  // NOTE: the program memory has no reset so it survives rst_n; only the
  // small stack is cleared, which is why it lives in the reset process below.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) imem_q[prog_addr] <= prog_data;
  end

  assign instr                  = imem_q[pc_q];
  assign {f_op, f_s1, f_s2, f_dst} = instr;
  assign fetch_ok               = in_range(f_s1) && in_range(f_s2) && in_range(f_dst);
  assign last_instr             = ({1'b0, pc_q} == len_q - (AW+1)'(1));
  assign len_clamped            = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < STACK; i++) begin
      if (f_s1 == IW'(i)) rd_a = stack_q[i];
      if (f_s2 == IW'(i)) rd_b = stack_q[i];
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      hold_q  <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      for (int i = 0; i < STACK; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      stack_q <= stack_d;
    end
  end

  always_comb begin
    // NOTE: defaulting every _d to its _q first keeps this block latch-free.
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    err_d   = err_q;
    res_d   = res_q;
    hold_d  = hold_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    stack_d = stack_q;
    case (state_q)
      S_IDLE: begin
        if (const_we) begin
          for (int i = 0; i < STACK; i++) begin
            if (const_idx == IW'(i)) stack_d[i] = const_value;
          end
        end
        if (start) begin
          if (prog_len == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_FETCH;
            len_d   = len_clamped;
            pc_d    = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_FETCH: begin
        if (!fetch_ok) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          opc_d   = f_op;
          a_d     = rd_a;
          b_d     = (f_op == OP_NEG) ? '0 : rd_b;
          dst_d   = f_dst;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_result_valid) begin
          hold_d  = op_result;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        for (int i = 0; i < STACK; i++) begin
          if (dst_q == IW'(i)) stack_d[i] = hold_q;
        end
        res_d = hold_q;
        if (last_instr) begin
          state_d = S_FINISH;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_valid = (state_q == S_ISSUE);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FINISH);
    op_code  = opc_q;
    op_a     = a_q;
    op_b     = b_q;
    error    = err_q;
    result   = res_q;
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: the bench plays the datapath and compares
// issued operands, cycle timing and results against hand-computed values.
module tb_op_sequencer;
  localparam int N          = 32;
  localparam int Q          = 16;
  localparam int STACK      = 5;
  localparam int PROG_DEPTH = 16;
  localparam int IW         = 3;
  localparam int AW         = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW:0]       prog_len;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [2+3*IW-1:0] prog_data;
  logic              const_we;
  logic [IW-1:0]     const_idx;
  logic [N-1:0]      const_value;
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [N-1:0]      op_a;
  logic [N-1:0]      op_b;
  logic              op_result_valid;
  logic [N-1:0]      op_result;
  logic              busy;
  logic              done;
  logic              error;
  logic [N-1:0]      result;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int valid_cnt  = 0;
  int accept_cnt = 0;

  op_sequencer #(.N(N), .Q(Q), .STACK(STACK), .PROG_DEPTH(PROG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .const_we(const_we), .const_idx(const_idx), .const_value(const_value),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_result_valid(op_result_valid),
    .op_result(op_result), .busy(busy), .done(done), .error(error),
    .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (op_valid) valid_cnt <= valid_cnt + 1;
    if (op_valid && op_ready) accept_cnt <= accept_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2+3*IW-1:0] ins(input logic [1:0] op, input logic [IW-1:0] s1,
                                            input logic [IW-1:0] s2, input logic [IW-1:0] d);
    return {op, s1, s2, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_instr(input logic [AW-1:0] addr, input logic [2+3*IW-1:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    step();
    prog_we = 1'b0;
  endtask

  task automatic write_const(input logic [IW-1:0] idx, input logic [N-1:0] val);
    const_we = 1'b1; const_idx = idx; const_value = val;
    step();
    const_we = 1'b0;
  endtask

  task automatic start_prog(input logic [AW:0] len, output int sc);
    start = 1'b1; prog_len = len; sc = cyc;
    step();
    start = 1'b0;
  endtask

  // Acts as the datapath for one operation: captures the request, holds
  // op_ready low for 'stall' cycles, then returns 'resp' 'rdelay' cycles after accept.
  task automatic serve_op(input logic [N-1:0] resp, input int stall, input int rdelay,
                          output logic [1:0] code, output logic [N-1:0] a,
                          output logic [N-1:0] b, output bit stable, output bit seen);
    int n = 0;
    stable = 1'b1;
    while (op_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    seen = (op_valid === 1'b1);
    code = op_code; a = op_a; b = op_b;
    if (!seen) return;
    for (int i = 0; i < stall; i++) begin
      step();
      if (op_valid !== 1'b1 || op_code !== code || op_a !== a || op_b !== b) stable = 1'b0;
    end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    for (int i = 1; i < rdelay; i++) step();
    op_result_valid = 1'b1; op_result = resp;
    step();
    op_result_valid = 1'b0; op_result = '0;
  endtask

  // Returns cycles from start to the done pulse (-1 on timeout), then steps past it.
  task automatic wait_done(input int sc, output int delta);
    int n = 0;
    delta = -1;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (done === 1'b1) begin
      delta = cyc - sc;
      step();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({op_valid, busy, done, error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {op_valid, busy, done, error});
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
  endtask

  task automatic test_add();
    int sc, d, dc0;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    write_const(0, 32'h0001_8000);
    write_const(1, 32'h0002_4000);
    write_instr(0, ins(OP_ADD, 0, 1, 2));
    dc0 = done_cnt;
    start_prog(1, sc);
    serve_op(32'h0003_C000, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || code !== OP_ADD || a !== 32'h0001_8000 || b !== 32'h0002_4000) begin
      n_fail++;
      $display("FAIL add_issue: got seen=%0d code=%b a=%h b=%h expected 1 00 00018000 00024000",
               seen, code, a, b);
    end
    wait_done(sc, d);
    n_checks++;
    if (d != 5) begin
      n_fail++;
      $display("FAIL add_done_cycle: got %0d expected 5", d);
    end
    n_checks++;
    if (result !== 32'h0003_C000) begin
      n_fail++;
      $display("FAIL add_result: got %h expected 0003c000", result);
    end
    n_checks++;
    if (done_cnt - dc0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done_once: got pulses=%0d busy=%b expected 1 0", done_cnt - dc0, busy);
    end
    // stack[2] must now hold the written result
    write_instr(0, ins(OP_ADD, 2, 1, 3));
    start_prog(1, sc);
    serve_op(32'h0006_0000, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || a !== 32'h0003_C000) begin
      n_fail++;
      $display("FAIL add_stack2: got seen=%0d a=%h expected 1 0003c000", seen, a);
    end
    wait_done(sc, d);
  endtask

  task automatic test_chain();
    int sc, d, dc0;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    write_const(1, 32'h0002_0000);
    write_instr(0, ins(OP_MUL, 0, 1, 2));
    write_instr(1, ins(OP_SUB, 2, 0, 3));
    dc0 = done_cnt;
    start_prog(2, sc);
    serve_op(32'h0003_0000, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || code !== OP_MUL || a !== 32'h0001_8000 || b !== 32'h0002_0000) begin
      n_fail++;
      $display("FAIL chain_issue1: got seen=%0d code=%b a=%h b=%h expected 1 10 00018000 00020000",
               seen, code, a, b);
    end
    serve_op(32'h0001_8000, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || code !== OP_SUB || a !== 32'h0003_0000 || b !== 32'h0001_8000) begin
      n_fail++;
      $display("FAIL chain_issue2_raw: got seen=%0d code=%b a=%h b=%h expected 1 01 00030000 00018000",
               seen, code, a, b);
    end
    wait_done(sc, d);
    n_checks++;
    if (d != 9 || result !== 32'h0001_8000 || done_cnt - dc0 != 1) begin
      n_fail++;
      $display("FAIL chain_finish: got cycles=%0d result=%h pulses=%0d expected 9 00018000 1",
               d, result, done_cnt - dc0);
    end
  endtask

  task automatic test_negate();
    int sc, d;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    write_instr(0, ins(OP_NEG, 0, 3, 4));
    start_prog(1, sc);
    serve_op(32'hFFFE_8000, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || code !== OP_NEG || a !== 32'h0001_8000 || b !== '0) begin
      n_fail++;
      $display("FAIL neg_issue: got seen=%0d code=%b a=%h b=%h expected 1 11 00018000 00000000",
               seen, code, a, b);
    end
    wait_done(sc, d);
    n_checks++;
    if (d != 5 || result !== 32'hFFFE_8000) begin
      n_fail++;
      $display("FAIL neg_finish: got cycles=%0d result=%h expected 5 fffe8000", d, result);
    end
  endtask

  task automatic test_backpressure();
    int sc, d, ac0;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    write_instr(0, ins(OP_ADD, 0, 1, 2));
    ac0 = accept_cnt;
    start_prog(1, sc);
    serve_op(32'h0003_8000, 3, 2, code, a, b, stable, seen);
    // start while busy (WRITE) must not restart the program
    start = 1'b1; prog_len = 1;
    step();
    start = 1'b0;
    wait_done(sc, d);
    n_checks++;
    if (!seen || !stable || a !== 32'h0001_8000 || b !== 32'h0002_0000) begin
      n_fail++;
      $display("FAIL bp_operands: got seen=%0d stable=%0d a=%h b=%h expected 1 1 00018000 00020000",
               seen, stable, a, b);
    end
    n_checks++;
    if (d != 9) begin
      n_fail++;
      $display("FAIL bp_done_cycle: got %0d expected 9", d);
    end
    n_checks++;
    if (accept_cnt - ac0 != 1 || busy !== 1'b0 || result !== 32'h0003_8000) begin
      n_fail++;
      $display("FAIL bp_single_issue: got accepts=%0d busy=%b result=%h expected 1 0 00038000",
               accept_cnt - ac0, busy, result);
    end
  endtask

  task automatic test_illegal();
    int sc, d, vc0;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    write_instr(0, ins(OP_ADD, 0, 1, 7));
    vc0 = valid_cnt;
    start_prog(1, sc);
    wait_done(sc, d);
    n_checks++;
    if (d != 2 || valid_cnt - vc0 != 0) begin
      n_fail++;
      $display("FAIL illegal_flow: got cycles=%0d valid_cycles=%0d expected 2 0", d, valid_cnt - vc0);
    end
    n_checks++;
    if (error !== 1'b1 || result !== 32'h0003_8000) begin
      n_fail++;
      $display("FAIL illegal_error: got error=%b result=%h expected 1 00038000", error, result);
    end
    write_instr(0, ins(OP_ADD, 0, 1, 2));
    start_prog(1, sc);
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got error=%b expected 0", error);
    end
    serve_op(32'h0000_1111, 0, 1, code, a, b, stable, seen);
    wait_done(sc, d);
  endtask

  task automatic test_reset_mid();
    int sc, d;
    logic [1:0] code; logic [N-1:0] a, b; bit stable, seen;
    start_prog(1, sc);
    step();
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({op_valid, busy, done, error} !== 4'b0000 || result !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flags=%b result=%h expected 0000 0",
               {op_valid, busy, done, error}, result);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    // program memory survives reset; the stack does not
    start_prog(1, sc);
    serve_op(32'h1234_5678, 0, 1, code, a, b, stable, seen);
    n_checks++;
    if (!seen || code !== OP_ADD || a !== '0 || b !== '0) begin
      n_fail++;
      $display("FAIL midreset_stack: got seen=%0d code=%b a=%h b=%h expected 1 00 0 0",
               seen, code, a, b);
    end
    wait_done(sc, d);
    n_checks++;
    if (d != 5 || result !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL midreset_run: got cycles=%0d result=%h expected 5 12345678", d, result);
    end
    start_prog(0, sc);
    n_checks++;
    if (done !== 1'b1 || result !== 32'h1234_5678 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got done=%b result=%h error=%b expected 1 12345678 0",
               done, result, error);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_end: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_len = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    const_we = 1'b0; const_idx = '0; const_value = '0;
    op_ready = 1'b0; op_result_valid = 1'b0; op_result = '0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    test_add();
    test_chain();
    test_negate();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
